alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, setting the operand/result width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset; synchronous, active-low.
REQ-004 The block SHALL have ports req0_valid/req1_valid, input, 1, requester i has a command pending.
REQ-005 The block SHALL have ports req0_a/req1_a and req0_b/req1_b, input, N, operands A and B of requester i.
REQ-006 The block SHALL have ports req0_op/req1_op, input, 3, the opcode of requester i.
REQ-007 The block SHALL have ports req0_ready/req1_ready, output, 1, one-cycle accept pulse to requester i.
REQ-008 The block SHALL have port rsp_valid, output, 1, response available.
REQ-009 The block SHALL have port rsp_ready, input, 1, the consumer takes the response.
REQ-010 The block SHALL have port rsp_id, output, 1, index of the requester that owns the response.
REQ-011 The block SHALL have port rsp_result, output, N, the registered ALU result.
REQ-012 The block SHALL have port rsp_flags, output, 4, registered flags {N,Z,V,C}, bit 3 = N.
REQ-013 The block SHALL have port rsp_err, output, 1, set when the opcode was illegal.
REQ-014 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-015 The opcodes SHALL be 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shift-left A by B, 110 shift-right A by B; 111 is illegal.
REQ-016 The FSM SHALL have exactly three states, IDLE, EXEC and RESP.
REQ-017 In IDLE with exactly one reqi_valid high, the block SHALL assert reqi_ready for that cycle, latch a/b/op/id and go to EXEC.
REQ-018 In IDLE with both valids high, the block SHALL grant the requester that is not last_grant, where last_grant resets to 1 so requester 0 wins first.
REQ-019 last_grant SHALL update only on a grant; an uncontended grant also updates it.
REQ-020 In IDLE with no valid, the block SHALL stay in IDLE and all ready outputs SHALL remain 0.
REQ-021 In EXEC, the block SHALL drive the ALU from the latched registers, capture result and flags into the rsp_* registers, set rsp_valid and go to RESP.
REQ-022 If the latched opcode is 111, the block SHALL report rsp_result=0, rsp_flags=0000 and rsp_err=1; otherwise rsp_err SHALL be 0.
REQ-023 In RESP, rsp_valid and all rsp_* outputs SHALL hold stable until a cycle with rsp_ready=1, after which rsp_valid clears and the FSM goes to IDLE.
REQ-024 Latency SHALL be fixed: accept at cycle t gives rsp_valid at t+2, and the minimum issue interval is 3 cycles.
REQ-025 Requests arriving while busy SHALL NOT be accepted; requesters hold valid and their fields until their ready pulse.
REQ-026 rsp_ready asserted while rsp_valid=0 SHALL be ignored.
REQ-027 At most one reqi_ready SHALL be high in any cycle.

Reset
REQ-028 While rst_n=0 at a clock edge, the block SHALL enter IDLE and set rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_err=0, rsp_id=0, last_grant=1, both ready outputs 0 and busy=0.
REQ-029 A reset in EXEC or RESP SHALL discard the in-flight command, and no response SHALL be emitted for it.

Structure
REQ-030 Shared package alu_pkg SHALL hold the opcode enum (3-bit), the FSM state enum and the flag bit-index constants.
REQ-031 The block SHALL instantiate the existing ALU module once as its only sub-module, parameterised with N, with the ALU's display outputs left unconnected.
REQ-032 The implementation SHALL be 120-400 lines of RTL.

Verification
REQ-033 The bench SHALL cover: req0 only, a=0100, b=0011, op=000 -> req0_ready at t, rsp_valid at t+2, result 0111, flags 0000, id 0.
REQ-034 The bench SHALL cover: both valid from reset, req0 add 1111+0011 and req1 sub 0100-0011 -> req0 served first with result 0010 and C=1, then req1 with result 0001 and id 1.
REQ-035 The bench SHALL cover: both valid continuously for 4 grants -> grant ids alternate 0,1,0,1.
REQ-036 The bench SHALL cover: req1 op=111 -> rsp_err=1, result 0000, flags 0000.
REQ-037 The bench SHALL cover: rsp_ready held low for 5 cycles in RESP -> rsp_* stable, no ready pulses, busy=1; after rsp_ready=1 for one cycle -> IDLE next cycle.
REQ-038 The bench SHALL cover: rst_n=0 during EXEC -> next cycle IDLE and rsp_valid=0, and no response appears for the dropped command.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: opcodes, arbiter FSM states and flag bit positions.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_ILL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

    // Bit positions inside the 4-bit {N,Z,V,C} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

endpackage

// File: rtl/alu_arbiter_if.sv
// Two-requester command bus plus response channel of the ALU arbiter.
interface alu_arbiter_if #(
    parameter int N = 4
) ();
    logic         req0_valid;
    logic         req1_valid;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic [2:0]   req0_op;
    logic [2:0]   req1_op;
    logic         req0_ready;
    logic         req1_ready;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [N-1:0] rsp_result;
    logic [3:0]   rsp_flags;
    logic         rsp_err;
    logic         busy;

    // master: requesters and response consumer; slave: the arbiter itself
    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        output req0_op, req1_op, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result,
        input  rsp_flags, rsp_err, busy
    );

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        input  req0_op, req1_op, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result,
        output rsp_flags, rsp_err, busy
    );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational N-bit ALU with {N,Z,V,C} flags, illegal-opcode error and a
// seven-segment view of the low result nibble.
module alu
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  op_e          op,
    output logic [N-1:0] result,
    output logic [3:0]   flags,
    output logic         err,
    output logic [6:0]   disp_seg
);

    logic [N:0]          wide;
    logic                carry;
    logic                ovf;
    logic signed [N-1:0] sa;
    logic signed [N-1:0] sb;
    logic signed [N-1:0] sr;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] seg;
        case (h)
            4'h0: seg = 7'b0111111;
            4'h1: seg = 7'b0000110;
            4'h2: seg = 7'b1011011;
            4'h3: seg = 7'b1001111;
            4'h4: seg = 7'b1100110;
            4'h5: seg = 7'b1101101;
            4'h6: seg = 7'b1111101;
            4'h7: seg = 7'b0000111;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1101111;
            4'ha: seg = 7'b1110111;
            4'hb: seg = 7'b1111100;
            4'hc: seg = 7'b0111001;
            4'hd: seg = 7'b1011110;
            4'he: seg = 7'b1111001;
            default: seg = 7'b1110001;
        endcase
        return seg;
    endfunction

    always_comb begin
        wide   = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        err    = 1'b0;
        result = '0;
        flags  = '0;
        sa     = a;
        sb     = b;
        unique case (op)
            OP_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[N-1:0];
                carry  = wide[N];
            end
            // Subtract as A + ~B + 1, so C=1 means no borrow (A >= B)
            OP_SUB: begin
                wide   = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
                result = wide[N-1:0];
                carry  = wide[N];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_SHL: result = a << b;
            OP_SHR: result = a >> b;
            default: err = 1'b1;
        endcase
        sr = result;
        if (op == OP_ADD) begin
            ovf = ((sa < 0) == (sb < 0)) && ((sr < 0) != (sa < 0));
        end else if (op == OP_SUB) begin
            ovf = ((sa < 0) != (sb < 0)) && ((sr < 0) != (sa < 0));
        end
        if (!err) begin
            flags[FLAG_N] = (sr < 0);
            flags[FLAG_Z] = (result == '0);
            flags[FLAG_V] = ovf;
            flags[FLAG_C] = carry;
        end
    end

    assign disp_seg = hex7(4'(result));

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter between two ALU requesters: grant, execute once,
// hold the registered response until the consumer takes it.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);

    state_e       state;
    logic         last_grant;
    logic         grant_any;
    logic         grant_id;

    logic [N-1:0] a_p0;
    logic [N-1:0] b_p0;
    op_e          op_p0;
    logic         id_p0;

    logic [N-1:0] alu_res;
    logic [3:0]   alu_flags;
    logic         alu_err;

    logic         vld_p1;
    logic [N-1:0] res_p1;
    logic [3:0]   flags_p1;
    logic         err_p1;
    logic         id_p1;

    // Ready is a same-cycle accept; gating with rst_n keeps it low during reset
    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (rst_n && state == IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_any = 1'b1;
                grant_id  = ~last_grant;
            end else if (bus.req0_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b0;
            end else if (bus.req1_valid) begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign bus.req0_ready = grant_any && !grant_id;
    assign bus.req1_ready = grant_any &&  grant_id;
    assign bus.busy       = (state != IDLE);

    alu #(.N(N)) u_alu (
        .a        (a_p0),
        .b        (b_p0),
        .op       (op_p0),
        .result   (alu_res),
        .flags    (alu_flags),
        .err      (alu_err),
        .disp_seg ()
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            vld_p1     <= 1'b0;
            res_p1     <= '0;
            flags_p1   <= '0;
            err_p1     <= 1'b0;
            id_p1      <= 1'b0;
        end else begin
            unique case (state)
                // p0: latch the granted command
                IDLE: begin
                    if (grant_any) begin
                        last_grant <= grant_id;
                        id_p0      <= grant_id;
                        if (grant_id) begin
                            a_p0  <= bus.req1_a;
                            b_p0  <= bus.req1_b;
                            op_p0 <= op_e'(bus.req1_op);
                        end else begin
                            a_p0  <= bus.req0_a;
                            b_p0  <= bus.req0_b;
                            op_p0 <= op_e'(bus.req0_op);
                        end
                        state <= EXEC;
                    end
                end
                // p1: capture the ALU output into the response registers
                EXEC: begin
                    res_p1   <= alu_res;
                    flags_p1 <= alu_flags;
                    err_p1   <= alu_err;
                    id_p1    <= id_p0;
                    vld_p1   <= 1'b1;
                    state    <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        vld_p1 <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid  = vld_p1;
    assign bus.rsp_result = res_p1;
    assign bus.rsp_flags  = flags_p1;
    assign bus.rsp_err    = err_p1;
    assign bus.rsp_id     = id_p1;

endmodule
